// File: rtl/wb_uart_bus_master.sv
// UART byte-stream to Wishbone classic single-transfer initiator (host debug / ISP loader).
// Optional bus watchdog: define WB_TIMEOUT_EN to abort a stalled cycle after TIMEOUT_CYCLES.
module wb_uart_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_BUS, S_SEND_STATUS, S_SEND_DATA
  } state_e;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ST_ACK = 8'h06;
  localparam logic [7:0] ST_NAK = 8'h15;

  if (CNT_W < 32) begin : g_cnt_chk
    if ((32'd1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_too_narrow
      $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end
  end

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdat_q, rdat_d;
  logic [7:0]  status_q, status_d;
  logic        cyc_q, cyc_d;
  logic [3:0]  sel_q, sel_d;
  logic        rx_ready_q, rx_ready_d;
  logic        busy_q, busy_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic        rx_fire, tx_fire, bus_timeout, bus_done, bus_fail;
  logic [1:0]  cnt_inc;

  assign rx_fire = rx_valid_i & rx_ready_q;
  assign tx_fire = tx_valid_q & tx_ready_i;
  assign cnt_inc = cnt_q + 2'd1;

`ifdef WB_TIMEOUT_EN
  // Watchdog counts BUS cycles; it is held at zero elsewhere so it clears on BUS entry.
  logic [CNT_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = '0;
    if (state_q == S_BUS) tmo_d = tmo_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end

  assign bus_timeout = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign bus_timeout = 1'b0;
`endif

  // err beats ack; ack beats a watchdog expiry in the same cycle
  assign bus_done = wb_ack_i | wb_err_i | bus_timeout;
  assign bus_fail = wb_err_i | (bus_timeout & ~wb_ack_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      status_q   <= '0;
      cyc_q      <= 1'b0;
      sel_q      <= '0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      rdat_q     <= rdat_d;
      status_q   <= status_d;
      cyc_q      <= cyc_d;
      sel_q      <= sel_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (rx_fire && (rx_data_i == CMD_WR || rx_data_i == CMD_RD)) state_d = S_GET_ADDR;
      S_GET_ADDR:
        if (rx_fire && cnt_q == 2'd3) state_d = we_q ? S_GET_DATA : S_BUS;
      S_GET_DATA:
        if (rx_fire && cnt_q == 2'd3) state_d = S_BUS;
      S_BUS:
        if (bus_done) state_d = S_SEND_STATUS;
      S_SEND_STATUS:
        if (tx_fire) state_d = (!we_q && status_q == ST_ACK) ? S_SEND_DATA : S_IDLE;
      S_SEND_DATA:
        if (tx_fire && cnt_q == 2'd3) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; status byte is loaded one cycle after SEND_STATUS entry
  always_comb begin
    cnt_d      = cnt_q;
    we_d       = we_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    rdat_d     = rdat_q;
    status_d   = status_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    cyc_d      = (state_d == S_BUS);
    sel_d      = (state_d == S_BUS) ? 4'hF : 4'h0;
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_GET_ADDR) || (state_d == S_GET_DATA);
    busy_d     = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_fire && rx_data_i == CMD_WR) we_d = 1'b1;
        if (rx_fire && rx_data_i == CMD_RD) we_d = 1'b0;
      end
      S_GET_ADDR:
        if (rx_fire) begin
          adr_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          cnt_d = cnt_inc;
        end
      S_GET_DATA:
        if (rx_fire) begin
          wdat_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          cnt_d = cnt_inc;
        end
      S_BUS:
        if (bus_done) begin
          status_d = bus_fail ? ST_NAK : ST_ACK;
          if (!we_q) rdat_d = wb_dat_i;
        end
      S_SEND_STATUS:
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = status_q;
        end else if (tx_ready_i) begin
          if (state_d == S_SEND_DATA) begin
            tx_data_d = rdat_q[7:0];
          end else begin
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
          end
        end
      S_SEND_DATA:
        if (tx_fire) begin
          cnt_d = cnt_inc;
          if (cnt_q == 2'd3) begin
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
          end else begin
            tx_data_d = rdat_q[{cnt_inc, 3'b000} +: 8];
          end
        end
      default: ;
    endcase
  end

  assign rx_ready_o = rx_ready_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = wdat_q;
  assign wb_sel_o   = sel_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_wb_uart_bus_master.sv
// Directed self-checking bench for wb_uart_bus_master with a simple Wishbone slave model.
module tb_wb_uart_bus_master;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  // slave model controls and observations
  int          sl_wait = 0;
  bit          sl_ack = 1'b1;
  bit          sl_err = 1'b0;
  logic [31:0] sl_rdata = '0;
  int          wait_cnt = 0;
  int          stb_cycles = 0;
  logic [31:0] snap_adr = '0, snap_dat = '0;
  logic        snap_we = 1'b0;
  logic [3:0]  snap_sel = '0;

  wb_uart_bus_master #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slave: responds after sl_wait stb cycles; ack/err drop once cyc falls
  initial begin
    forever begin
      step();
      if (wb_stb) begin
        stb_cycles++;
        snap_adr = wb_adr; snap_dat = wb_dat_o; snap_we = wb_we; snap_sel = wb_sel;
        if (wait_cnt >= sl_wait && (sl_ack || sl_err)) begin
          wb_ack = sl_ack; wb_err = sl_err; wb_dat_i = sl_rdata;
        end else begin
          wait_cnt++;
        end
      end else begin
        wb_ack = 1'b0; wb_err = 1'b0; wait_cnt = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      if (rx_ready) done = 1'b1;
      step();
    end
    rx_valid = 1'b0;
    if (!done) check("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  // Wait for a tx byte, stall it for 'hold' cycles checking stability, then take it
  task automatic recv_check(input string tag, input logic [7:0] exp, input int hold);
    bit seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      if (tx_valid) seen = 1'b1;
      else step();
    end
    if (!seen) begin
      check({tag, "_valid_timeout"}, 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < hold; i++) begin
        check({tag, "_hold"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, exp});
        step();
      end
      check(tag, 32'(tx_data), 32'(exp));
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check(tag, {30'd0, tx_valid, busy}, 32'd0);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    step(); step();
    check("rst_wb", {wb_cyc, wb_stb, wb_we, wb_sel}, 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
    check("rst_rdy_busy", {30'd0, rx_ready, busy}, 32'd0);
    rst = 1'b0;
    check("rel_rdy", 32'(rx_ready), 32'd0);
    step();
    check("idle_rdy", {30'd0, rx_ready, busy}, 32'd2);

    // Write with 2 wait states
    sl_wait = 2; sl_ack = 1'b1; sl_err = 1'b0; stb_cycles = 0;
    send_write(32'h0000_0010, 32'hDEAD_BEEF);
    check("wr_busy", 32'(busy), 32'd1);
    recv_check("wr_status", 8'h06, 0);
    check("wr_stb_cycles", 32'(stb_cycles), 32'd3);
    check("wr_adr", snap_adr, 32'h0000_0010);
    check("wr_dat", snap_dat, 32'hDEAD_BEEF);
    check("wr_we_sel", {27'd0, snap_we, snap_sel}, {27'd0, 1'b1, 4'hF});
    expect_quiet("wr_quiet", 2);

    // Read, zero-wait ack, with latency and back-pressure checks
    sl_wait = 0; sl_rdata = 32'h1234_5678; stb_cycles = 0;
    send_read(32'h0000_0004);
    check("rd_stb_n1", {30'd0, wb_cyc, wb_stb}, 32'd3);
    step();
    check("rd_stb_n2", {29'd0, wb_stb, wb_cyc, tx_valid}, 32'd0);
    step();
    check("rd_txv_n3", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h06});
    recv_check("rd_status", 8'h06, 0);
    recv_check("rd_b0", 8'h78, 5);
    recv_check("rd_b1", 8'h56, 0);
    recv_check("rd_b2", 8'h34, 0);
    recv_check("rd_b3", 8'h12, 0);
    check("rd_adr", snap_adr, 32'h0000_0004);
    check("rd_we_sel", {27'd0, snap_we, snap_sel}, {27'd0, 1'b0, 4'hF});
    check("rd_stb_cycles", 32'(stb_cycles), 32'd1);
    expect_quiet("rd_quiet", 2);

    // ack and err together: err wins, no data bytes
    sl_ack = 1'b1; sl_err = 1'b1; stb_cycles = 0;
    send_read(32'h0000_0100);
    step();
    check("err_cyc_drop", {30'd0, wb_cyc, wb_stb}, 32'd0);
    recv_check("err_status", 8'h15, 0);
    check("err_stb_cycles", 32'(stb_cycles), 32'd1);
    expect_quiet("err_quiet", 4);

    // Garbage bytes ignored, then a valid write
    sl_ack = 1'b1; sl_err = 1'b0; sl_wait = 1; stb_cycles = 0;
    send_byte(8'h00);
    send_byte(8'hFF);
    check("garb_idle", {29'd0, busy, rx_ready, wb_cyc}, 32'd2);
    check("garb_nobus", 32'(stb_cycles), 32'd0);
    send_write(32'h8000_0020, 32'hCAFE_F00D);
    recv_check("garb_wr_status", 8'h06, 0);
    check("garb_wr_adr", snap_adr, 32'h8000_0020);
    check("garb_wr_dat", snap_dat, 32'hCAFE_F00D);
    check("garb_stb_cycles", 32'(stb_cycles), 32'd2);

    // Reset while stb is high (slave never answers)
    sl_ack = 1'b0; sl_err = 1'b0; sl_wait = 0;
    send_write(32'h0000_0040, 32'h0000_0001);
    step();
    check("rst_pre_stb", 32'(wb_stb), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async", {29'd0, wb_cyc, wb_stb, tx_valid}, 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    step(); step();
    rst = 1'b0;
    check("rst_rel_rdy", 32'(rx_ready), 32'd0);
    sl_ack = 1'b1; sl_rdata = 32'hA5B6_C7D8; stb_cycles = 0;
    send_read(32'h0000_0008);
    recv_check("post_rst_status", 8'h06, 0);
    recv_check("post_rst_b0", 8'hD8, 0);
    recv_check("post_rst_b1", 8'hC7, 0);
    recv_check("post_rst_b2", 8'hB6, 0);
    recv_check("post_rst_b3", 8'hA5, 0);
    check("post_rst_adr", snap_adr, 32'h0000_0008);

`ifdef WB_TIMEOUT_EN
    // Slave never answers: watchdog aborts after 8 strobe cycles
    sl_ack = 1'b0; sl_err = 1'b0; stb_cycles = 0;
    send_read(32'h0000_0200);
    recv_check("tmo_status", 8'h15, 0);
    check("tmo_stb_cycles", 32'(stb_cycles), 32'd8);
    expect_quiet("tmo_quiet", 4);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
